// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared types and constants for reg_bus_sequencer.
//   state_t     - transfer sequencing states
//   BUS_W       - CPU bus data width
//   re_all_off  - all-ones source for the "every register tri-stated" RE value
package reg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int BUS_W    = 16;
  localparam int MAX_REGS = 1024;

  // Callers truncate to their bank size.
  function automatic logic [MAX_REGS-1:0] re_all_off();
    return '1;
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     - request vector
//   ptr     - highest-priority requester this round (owned by the caller)
//   gnt     - one-hot grant
//   gnt_idx - index of the granted requester
//   any     - at least one request present
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            any
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    // Search ptr, ptr+1, ... wrapping; first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: round-robin sequencer for register-to-register moves on
// the shared CPU bus. Each transfer is IDLE -> SETUP -> WRITE -> HOLD; the
// source RE is low SETUP..HOLD, bracketing the single W cycle, and the IDLE
// dead cycle gives break-before-make between sources.
// Ports:
//   CLK, RSTN       - clock, async active-low reset
//   REQ/SRC/DST     - per-requester request and packed source/dest indices
//   ACK             - one-cycle one-hot completion pulse (in HOLD)
//   RE, W           - per-register output disable / transparent write
//   BUSY            - not IDLE
//   IMM_SEL/IMM/BUS - immediate-data path, present only with REG_SEQ_IMM_EN
// All outputs are registered: the values for the state being entered are
// computed from next-state and registered on the same edge.
module reg_bus_sequencer
  import reg_seq_pkg::*;
#(
  parameter  int NREGS = 8,
  parameter  int NREQ  = 2,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*IW-1:0]    SRC,
  input  logic [NREQ*IW-1:0]    DST,
`ifdef REG_SEQ_IMM_EN
  input  logic [NREQ-1:0]       IMM_SEL,
  input  logic [NREQ*BUS_W-1:0] IMM,
  output wire  [BUS_W-1:0]      BUS,
`endif
  output logic [NREQ-1:0]       ACK,
  output logic [NREGS-1:0]      RE,
  output logic [NREGS-1:0]      W,
  output logic                  BUSY
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREGS-1:0] RE_OFF = NREGS'(re_all_off());

  state_t            state, nxt;
  logic [PW-1:0]     ptr, ptr_n;
  logic [IW-1:0]     src_q, src_n, dst_q, dst_n;
  logic [NREQ-1:0]   gnt_q, gnt_n;
  logic [NREGS-1:0]  re_n, w_n;
  logic [NREQ-1:0]   ack_n;
  logic              imm_sel_n;

  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (REQ),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  wire grant = (state == IDLE) && arb_any;

`ifdef REG_SEQ_IMM_EN
  logic             imm_sel_q, bus_en_q, bus_en_n;
  logic [BUS_W-1:0] imm_q, imm_n;

  always_comb begin
    imm_sel_n = imm_sel_q;
    imm_n     = imm_q;
    if (grant) begin
      imm_sel_n = IMM_SEL[arb_idx];
      imm_n     = IMM[int'(arb_idx)*BUS_W +: BUS_W];
    end
    bus_en_n = (nxt != IDLE) && imm_sel_n;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      bus_en_q  <= 1'b0;
    end else begin
      imm_sel_q <= imm_sel_n;
      imm_q     <= imm_n;
      bus_en_q  <= bus_en_n;
    end
  end

  assign BUS = bus_en_q ? imm_q : {BUS_W{1'bz}};
`else
  assign imm_sel_n = 1'b0;
`endif

  always_comb begin
    nxt   = state;
    ptr_n = ptr;
    src_n = src_q;
    dst_n = dst_q;
    gnt_n = gnt_q;
    case (state)
      IDLE: if (arb_any) begin
        nxt   = SETUP;
        src_n = SRC[int'(arb_idx)*IW +: IW];
        dst_n = DST[int'(arb_idx)*IW +: IW];
        gnt_n = arb_gnt;
        ptr_n = (int'(arb_idx) == NREQ-1) ? '0 : arb_idx + 1'b1;
      end
      SETUP:   nxt = WRITE;
      WRITE:   nxt = HOLD;
      HOLD:    nxt = IDLE;
      default: nxt = IDLE;
    endcase

    // Outputs for the state being entered, from the values latched with it.
    re_n  = RE_OFF;
    w_n   = '0;
    ack_n = '0;
    if (nxt != IDLE && !imm_sel_n)
      re_n[src_n] = 1'b0;
    // A register-to-itself move still sequences but must not write.
    if (nxt == WRITE && (imm_sel_n || src_n != dst_n))
      w_n[dst_n] = 1'b1;
    if (nxt == HOLD)
      ack_n = gnt_n;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      ptr   <= '0;
      src_q <= '0;
      dst_q <= '0;
      gnt_q <= '0;
      RE    <= RE_OFF;
      W     <= '0;
      ACK   <= '0;
      BUSY  <= 1'b0;
    end else begin
      state <= nxt;
      ptr   <= ptr_n;
      src_q <= src_n;
      dst_q <= dst_n;
      gnt_q <= gnt_n;
      RE    <= re_n;
      W     <= w_n;
      ACK   <= ack_n;
      BUSY  <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer (NREGS=8, NREQ=2). Expected per-cycle outputs
// are queued when a transfer is requested and popped one per falling edge.
// Define REG_SEQ_IMM_EN to include the immediate-data scenario.
`timescale 1ns/1ps
module tb_reg_bus_sequencer;
  localparam int NREGS = 8;
  localparam int NREQ  = 2;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic [1:0] REQ;
  logic [5:0] SRC, DST;
  wire  [1:0] ACK;
  wire  [7:0] RE, W;
  wire        BUSY;
`ifdef REG_SEQ_IMM_EN
  logic [1:0]  IMM_SEL;
  logic [31:0] IMM;
  wire  [15:0] BUS;
`endif

  reg_bus_sequencer #(.NREGS(NREGS), .NREQ(NREQ)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .SRC(SRC), .DST(DST),
`ifdef REG_SEQ_IMM_EN
    .IMM_SEL(IMM_SEL), .IMM(IMM), .BUS(BUS),
`endif
    .ACK(ACK), .RE(RE), .W(W), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  re;
    logic [7:0]  w;
    logic [1:0]  ack;
    logic        busy;
    logic [15:0] bus;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  // Phase 0 = IDLE, 1 = SETUP, 2 = WRITE, 3 = HOLD.
  function automatic exp_t model(int src, int dst, int g, bit imm, logic [15:0] immv, int ph);
    exp_t e;
    e.re   = 8'hFF;
    e.w    = 8'h00;
    e.ack  = 2'b00;
    e.busy = (ph != 0);
    e.bus  = 16'hzzzz;
    if (ph != 0 && !imm) e.re = ~(8'b1 << src);
    if (ph == 2 && (imm || src != dst)) e.w = 8'b1 << dst;
    if (ph == 3) e.ack = 2'b1 << g;
    if (ph != 0 && imm) e.bus = immv;
    return e;
  endfunction

  task automatic push_xfer(int src, int dst, int g, bit imm, logic [15:0] immv);
    for (int ph = 1; ph <= 4; ph++) q.push_back(model(src, dst, g, imm, immv, ph % 4));
  endtask

  task automatic test_reset();
    RSTN = 1'b0; REQ = '0; SRC = '0; DST = '0;
`ifdef REG_SEQ_IMM_EN
    IMM_SEL = '0; IMM = '0;
`endif
    #12;
    total++; if (RE !== 8'hFF) $display("FAIL reset re: got %h want ff", RE); else passed++;
    total++; if (W !== 8'h00) $display("FAIL reset w: got %h want 00", W); else passed++;
    total++; if (ACK !== 2'b00) $display("FAIL reset ack: got %b want 00", ACK); else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL reset busy: got %b want 0", BUSY); else passed++;
`ifdef REG_SEQ_IMM_EN
    total++; if (BUS !== 16'hzzzz) $display("FAIL reset bus: got %h want z", BUS); else passed++;
`endif
    @(negedge CLK); RSTN = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    SRC[2:0] = 3'd3; DST[2:0] = 3'd5; REQ = 2'b01;
    push_xfer(3, 5, 0, 0, 16'h0);
    while (q.size() != 0) begin
      @(negedge CLK); e = q.pop_front();
      total++; if (RE !== e.re) $display("FAIL single re: got %h want %h", RE, e.re); else passed++;
      total++; if (W !== e.w) $display("FAIL single w: got %h want %h", W, e.w); else passed++;
      total++; if (ACK !== e.ack) $display("FAIL single ack: got %b want %b", ACK, e.ack); else passed++;
      total++; if (BUSY !== e.busy) $display("FAIL single busy: got %b want %b", BUSY, e.busy); else passed++;
      REQ = REQ & ~e.ack;
    end
  endtask

  // A request that never spans a rising edge is never seen.
  task automatic test_withdraw();
    @(posedge CLK); #1 REQ = 2'b01;
    @(negedge CLK); REQ = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++; if (BUSY !== 1'b0) $display("FAIL withdraw busy: got %b want 0", BUSY); else passed++;
      total++; if (ACK !== 2'b00) $display("FAIL withdraw ack: got %b want 00", ACK); else passed++;
      total++; if (RE !== 8'hFF) $display("FAIL withdraw re: got %h want ff", RE); else passed++;
    end
  endtask

  task automatic test_src_eq_dst();
    exp_t e;
    SRC[5:3] = 3'd6; DST[5:3] = 3'd6; REQ = 2'b10;
    push_xfer(6, 6, 1, 0, 16'h0);
    while (q.size() != 0) begin
      @(negedge CLK); e = q.pop_front();
      total++; if (RE !== e.re) $display("FAIL srceqdst re: got %h want %h", RE, e.re); else passed++;
      total++; if (W !== e.w) $display("FAIL srceqdst w: got %h want %h", W, e.w); else passed++;
      total++; if (ACK !== e.ack) $display("FAIL srceqdst ack: got %b want %b", ACK, e.ack); else passed++;
      REQ = REQ & ~e.ack;
    end
  endtask

  task automatic test_contention();
    exp_t e;
    SRC = {3'd4, 3'd1}; DST = {3'd7, 3'd2}; REQ = 2'b11;
    for (int k = 0; k < 2; k++) begin
      push_xfer(1, 2, 0, 0, 16'h0);
      push_xfer(4, 7, 1, 0, 16'h0);
    end
    while (q.size() != 0) begin
      @(negedge CLK); e = q.pop_front();
      total++; if (RE !== e.re) $display("FAIL contention re: got %h want %h", RE, e.re); else passed++;
      total++; if (W !== e.w) $display("FAIL contention w: got %h want %h", W, e.w); else passed++;
      total++; if (ACK !== e.ack) $display("FAIL contention ack: got %b want %b", ACK, e.ack); else passed++;
      total++; if ($countones(~RE) > 1) $display("FAIL contention drivers: got re %h want at most one low", RE); else passed++;
    end
    REQ = 2'b00;
  endtask

  // SRC changes mid-transfer and REQ drops after grant; neither disturbs it.
  task automatic test_index_stability();
    exp_t e;
    int   cyc = 0;
    SRC[2:0] = 3'd3; DST[2:0] = 3'd5; REQ = 2'b01;
    push_xfer(3, 5, 0, 0, 16'h0);
    while (q.size() != 0) begin
      @(negedge CLK); e = q.pop_front(); cyc++;
      total++; if (RE !== e.re) $display("FAIL stability re: got %h want %h", RE, e.re); else passed++;
      total++; if (W !== e.w) $display("FAIL stability w: got %h want %h", W, e.w); else passed++;
      total++; if (ACK !== e.ack) $display("FAIL stability ack: got %b want %b", ACK, e.ack); else passed++;
      if (cyc == 1) begin SRC[2:0] = 3'd7; DST[2:0] = 3'd1; REQ = 2'b00; end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    SRC[2:0] = 3'd2; DST[2:0] = 3'd4; REQ = 2'b01;
    push_xfer(2, 4, 0, 0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); e = q.pop_front();
      total++; if (RE !== e.re) $display("FAIL rstmid pre re: got %h want %h", RE, e.re); else passed++;
      total++; if (W !== e.w) $display("FAIL rstmid pre w: got %h want %h", W, e.w); else passed++;
    end
    q.delete();
    RSTN = 1'b0; #1;
    total++; if (RE !== 8'hFF) $display("FAIL rstmid re: got %h want ff", RE); else passed++;
    total++; if (W !== 8'h00) $display("FAIL rstmid w: got %h want 00", W); else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL rstmid busy: got %b want 0", BUSY); else passed++;
    @(negedge CLK);
    total++; if (ACK !== 2'b00) $display("FAIL rstmid ack: got %b want 00", ACK); else passed++;
    RSTN = 1'b1;
    push_xfer(2, 4, 0, 0, 16'h0);
    while (q.size() != 0) begin
      @(negedge CLK); e = q.pop_front();
      total++; if (RE !== e.re) $display("FAIL rstmid post re: got %h want %h", RE, e.re); else passed++;
      total++; if (W !== e.w) $display("FAIL rstmid post w: got %h want %h", W, e.w); else passed++;
      total++; if (ACK !== e.ack) $display("FAIL rstmid post ack: got %b want %b", ACK, e.ack); else passed++;
      REQ = REQ & ~e.ack;
    end
  endtask

`ifdef REG_SEQ_IMM_EN
  task automatic test_imm();
    exp_t e;
    IMM_SEL = 2'b01; IMM[15:0] = 16'hBEEF; SRC[2:0] = 3'd3; DST[2:0] = 3'd2; REQ = 2'b01;
    push_xfer(3, 2, 0, 1, 16'hBEEF);
    while (q.size() != 0) begin
      @(negedge CLK); e = q.pop_front();
      total++; if (RE !== e.re) $display("FAIL imm re: got %h want %h", RE, e.re); else passed++;
      total++; if (W !== e.w) $display("FAIL imm w: got %h want %h", W, e.w); else passed++;
      total++; if (ACK !== e.ack) $display("FAIL imm ack: got %b want %b", ACK, e.ack); else passed++;
      total++; if (BUS !== e.bus) $display("FAIL imm bus: got %h want %h", BUS, e.bus); else passed++;
      REQ = REQ & ~e.ack;
    end
    IMM_SEL = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_withdraw();
    test_src_eq_dst();
    test_contention();
    test_index_stability();
    test_reset_mid();
`ifdef REG_SEQ_IMM_EN
    test_imm();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
